// File: rtl/t0_bus_decoder.sv
// -----------------------------------------------------------------------------
// t0_bus_decoder
//
// Receiver-side decoder for the T0 (zero-transition) address bus encoding.
// Rebuilds the original address stream from the encoded bus B and the INC
// line, flags an INC word that arrives with no reference address, and meters
// switching activity on the received {INC,B} lines.
//
// Ports
//   ck         in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-low
//   B          in   WIDTH  encoded bus from the T0 encoder
//   INC        in   1      1 = address is previous + STRIDE, B frozen
//   valid_in   in   1      B/INC qualify this cycle
//   cnt_clr    in   1      synchronous clear of the toggle counter (wins)
//   A          out  WIDTH  decoded address (registered)
//   valid_out  out  1      A updated this cycle
//   err        out  1      one-cycle pulse: INC=1 with no reference address
//   tog_cnt    out  CNTW   saturating count of bit transitions on {INC,B}
// -----------------------------------------------------------------------------
module t0_bus_decoder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned CNTW   = 16
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [WIDTH-1:0] B,
    input  logic             INC,
    input  logic             valid_in,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] A,
    output logic             valid_out,
    output logic             err,
    output logic [CNTW-1:0]  tog_cnt
);

    typedef enum logic {
        ST_EMPTY  = 1'b0,   // no reference address held
        ST_LOCKED = 1'b1    // r_last_addr is valid
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] r_last_addr;
    logic [WIDTH-1:0] w_last_nxt;
    logic             r_valid_out;
    logic             w_valid_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [WIDTH:0]   r_prev_bus;
    logic [CNTW-1:0]  r_tog_cnt;

    logic [WIDTH-1:0] w_inc_addr;
    logic [WIDTH:0]   w_bus_now;
    logic [WIDTH:0]   w_flips;
    logic [CNTW:0]    w_pop;
    logic [CNTW:0]    w_sum;
    logic [CNTW-1:0]  w_tog_sat;

    // Truncation to WIDTH bits gives the modulo-2^WIDTH wrap (8'hFF+1 -> 8'h00).
    assign w_inc_addr = r_last_addr + WIDTH'(STRIDE);

    // -------------------------------------------------------------------------
    // Decode FSM: next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_last_nxt  = r_last_addr;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        if (valid_in) begin
            if (!INC) begin
                // Literal address on the bus: always resynchronises the decoder.
                w_a_nxt     = B;
                w_last_nxt  = B;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_LOCKED;
            end else if (r_state == ST_LOCKED) begin
                // B is frozen by the encoder here; only the reference matters.
                w_a_nxt     = w_inc_addr;
                w_last_nxt  = w_inc_addr;
                w_valid_nxt = 1'b1;
            end else begin
                // Increment with nothing to increment from: report, keep A.
                w_err_nxt   = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Toggle meter: popcount of flipped lines, saturating accumulate
    // -------------------------------------------------------------------------
    assign w_bus_now = {INC, B};
    assign w_flips   = w_bus_now ^ r_prev_bus;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i <= int'(WIDTH); i++) begin
            w_pop = w_pop + (CNTW+1)'(w_flips[i]);
        end
    end

    // One extra sum bit catches the carry so the counter pins at all-ones.
    assign w_sum     = {1'b0, r_tog_cnt} + w_pop;
    assign w_tog_sat = w_sum[CNTW] ? '1 : w_sum[CNTW-1:0];

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_a         <= '0;
            r_last_addr <= '0;
            r_valid_out <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_last_addr <= w_last_nxt;
            r_valid_out <= w_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_prev_bus <= '0;
            r_tog_cnt  <= '0;
        end else begin
            // Clear discards this cycle's transitions but the bus history
            // still advances, so the next count is relative to this word.
            if (cnt_clr) begin
                r_tog_cnt <= '0;
            end else if (valid_in) begin
                r_tog_cnt <= w_tog_sat;
            end
            if (valid_in) begin
                r_prev_bus <= w_bus_now;
            end
        end
    end

    assign A         = r_a;
    assign valid_out = r_valid_out;
    assign err       = r_err;
    assign tog_cnt   = r_tog_cnt;

endmodule

// File: doc/t0_bus_decoder.md
Name: t0_bus_decoder

Overview:
- Receiver-side decoder for the T0 (zero-transition) address bus encoding; sits directly downstream of the T0 encoder and consumes its encoded bus plus INC line.
- Reconstructs the original address stream, flags protocol errors, and meters switching activity on the received lines.
- The meter lets the power-analysis benches compare T0 activity against the normal, bus-invert, transition-based and Gray buses at the receiving end.

Parameters:
- WIDTH, 8, address/bus width in bits.
- STRIDE, 1, address increment implied by INC=1; added modulo 2^WIDTH.
- CNTW, 16, toggle-counter width.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- B  in  WIDTH  encoded bus from the T0 encoder.
- INC  in  1  T0 increment line; 1 = address is previous + STRIDE, B frozen.
- valid_in  in  1  B/INC qualify this cycle.
- cnt_clr  in  1  synchronous clear of toggle counter.
- A  out  WIDTH  decoded address (registered).
- valid_out  out  1  A updated this cycle.
- err  out  1  one-cycle pulse: INC=1 received with no reference address.
- tog_cnt  out  CNTW  accumulated bit transitions on {INC,B}.

Behaviour:
- Reset: rst=0 forces, asynchronously, A=0, valid_out=0, err=0, tog_cnt=0, last_addr=0, prev_bus=0, state=EMPTY. Release is sampled on the next rising ck edge.
- Latency: 1 cycle. Inputs sampled at edge k appear on A/valid_out/err after edge k.
- FSM states:
  - EMPTY: no reference address held.
  - LOCKED: last_addr is valid.
- valid_in=1, INC=0 (any state): A<=B, last_addr<=B, valid_out<=1, state->LOCKED.
- valid_in=1, INC=1, LOCKED: A<=last_addr+STRIDE (wraps modulo 2^WIDTH, e.g. 8'hFF+1 -> 8'h00), last_addr<=same value, valid_out<=1. B is ignored for decoding.
- valid_in=1, INC=1, EMPTY: err<=1 for one cycle, valid_out<=0, A and state unchanged.
- valid_in=0: valid_out<=0, err<=0, A/last_addr/state/prev_bus held, no counting.
- Toggle meter, on each valid_in=1 cycle:
  - tog_cnt += popcount({INC,B} XOR prev_bus), then prev_bus<={INC,B}.
  - Range is 0..WIDTH+1 per cycle.
  - Saturates at 2^CNTW-1; never wraps.
- cnt_clr=1: tog_cnt<=0 and that cycle's transitions are discarded (clear wins). prev_bus still updates if valid_in=1.
- The first valid word after reset is compared against prev_bus=0.
- rst asserted mid-stream: all state is lost. The next INC=1 before an INC=0 word raises err.

Test Plan:
- Reset then valid_in with {INC=0,B=8'h3C} -> A=8'h3C, valid_out=1 one cycle later, state LOCKED, tog_cnt=4.
- After B=8'h3C: three INC=1 words with B held at 8'h3C -> A=8'h3D, 8'h3E, 8'h3F on consecutive cycles; tog_cnt +1 on the first (INC rise) only.
- LOCKED at 8'hFE, then INC=1 twice -> A=8'hFF, then 8'h00 (wrap); err stays 0.
- After reset, first word INC=1 B=8'h10 -> err=1 for one cycle, valid_out=0, A=0. Then INC=0 B=8'h10 -> A=8'h10.
- Preload tog_cnt near 16'hFFFF by driving alternating 8'h00/8'hFF words -> tog_cnt holds at 16'hFFFF. cnt_clr together with a 9-bit toggle -> tog_cnt=0.
- Drive rst=0 between edges mid-stream -> A, tog_cnt and valid_out go to 0 immediately; the following INC=1 word produces err=1.
